// File: rtl/mac_feeder.sv
// Packs variable-length dot-product groups into single-cycle lane-packed beats for the MAC array.
// Optional idle-flush timeout is built only when MAC_FEEDER_TIMEOUT_EN is defined.
module mac_feeder #(
    parameter int unsigned MAX_MACS          = 64,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned MAX_GROUPS        = 8,
    parameter int unsigned MAC_BIT_PER_GROUP = 6,
    parameter int unsigned TIMEOUT_CYCLES    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [MAC_BIT_PER_GROUP-1:0]          in_len,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]        in_data,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]        in_weight,
    input  logic                                  flush,
    output logic                                  out_valid,
    output logic [$clog2(MAX_GROUPS+1)-1:0]       out_num_groups,
    output logic [MAX_GROUPS*MAC_BIT_PER_GROUP-1:0] out_num_macs,
    output logic [MAX_MACS*DATA_WIDTH-1:0]        out_data,
    output logic [MAX_MACS*DATA_WIDTH-1:0]        out_weight,
    output logic                                  err_len
);
    localparam int unsigned VecW    = MAX_MACS * DATA_WIDTH;
    localparam int unsigned LenW    = MAX_GROUPS * MAC_BIT_PER_GROUP;
    localparam int unsigned LanesW  = $clog2(MAX_MACS + 1);
    localparam int unsigned GroupsW = $clog2(MAX_GROUPS + 1);
    localparam int unsigned SumW    = LanesW + 1;

    typedef enum logic [0:0] {StEmpty, StFilling} state_e;

    state_e              state_q, state_d;
    logic [LanesW-1:0]   lanes_q, lanes_d;
    logic [GroupsW-1:0]  groups_q, groups_d;
    logic [VecW-1:0]     data_q, data_d, weight_q, weight_d;
    logic [LenW-1:0]     len_q, len_d;
    logic                err_q, err_d;

    logic                out_valid_q;
    logic [GroupsW-1:0]  out_groups_q;
    logic [LenW-1:0]     out_len_q;
    logic [VecW-1:0]     out_data_q, out_weight_q;

    logic                accept, len_legal, fits, emit, timeout_fire;
    logic [SumW-1:0]     lanes_sum;
    logic [GroupsW-1:0]  groups_inc, emit_groups;
    logic [VecW-1:0]     mask_data, mask_weight, app_data, app_weight, emit_data, emit_weight;
    logic [LenW-1:0]     len_ins, app_len, emit_len;

    assign in_ready  = !rst && !flush;
    assign accept    = in_valid && in_ready;
    assign len_legal = (in_len != '0) && (32'(in_len) <= MAX_MACS);
    assign lanes_sum = SumW'(lanes_q) + SumW'(in_len);
    assign groups_inc = groups_q + GroupsW'(1);
    assign fits      = (lanes_sum <= SumW'(MAX_MACS)) && (groups_q < GroupsW'(MAX_GROUPS));

    // Lanes at or above in_len carry don't-care data and must not leak into the packet.
    always_comb begin
        mask_data   = '0;
        mask_weight = '0;
        for (int unsigned i = 0; i < MAX_MACS; i++) begin
            if (i < 32'(in_len)) begin
                mask_data[i*DATA_WIDTH +: DATA_WIDTH]   = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                mask_weight[i*DATA_WIDTH +: DATA_WIDTH] = in_weight[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign len_ins    = LenW'(in_len);
    assign app_data   = data_q | (mask_data << (lanes_q * DATA_WIDTH));
    assign app_weight = weight_q | (mask_weight << (lanes_q * DATA_WIDTH));
    assign app_len    = len_q | (len_ins << (groups_q * MAC_BIT_PER_GROUP));

`ifdef MAC_FEEDER_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IdleW-1:0] idle_q, idle_d;

    assign timeout_fire = (state_q == StFilling) && !accept && (idle_q == IdleW'(TIMEOUT_CYCLES));

    always_comb begin
        idle_d = idle_q;
        if (accept || emit) begin
            idle_d = '0;
        end else if (state_q == StFilling) begin
            idle_d = idle_q + IdleW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`else
    logic unused_timeout;
    assign timeout_fire   = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d     = state_q;
        lanes_d     = lanes_q;
        groups_d    = groups_q;
        data_d      = data_q;
        weight_d    = weight_q;
        len_d       = len_q;
        err_d       = err_q;
        emit        = 1'b0;
        emit_data   = data_q;
        emit_weight = weight_q;
        emit_len    = len_q;
        emit_groups = groups_q;
        if (accept) begin
            if (!len_legal) begin
                err_d = 1'b1;
            end else if (fits) begin
                if (lanes_sum == SumW'(MAX_MACS) || groups_inc == GroupsW'(MAX_GROUPS)) begin
                    emit        = 1'b1;
                    emit_data   = app_data;
                    emit_weight = app_weight;
                    emit_len    = app_len;
                    emit_groups = groups_inc;
                    lanes_d     = '0;
                    groups_d    = '0;
                    data_d      = '0;
                    weight_d    = '0;
                    len_d       = '0;
                end else begin
                    lanes_d  = LanesW'(lanes_sum);
                    groups_d = groups_inc;
                    data_d   = app_data;
                    weight_d = app_weight;
                    len_d    = app_len;
                end
            end else begin
                // Overflow: ship the old buffer as-is and restart it with this group.
                emit     = 1'b1;
                lanes_d  = LanesW'(in_len);
                groups_d = GroupsW'(1);
                data_d   = mask_data;
                weight_d = mask_weight;
                len_d    = len_ins;
            end
        end else if (state_q == StFilling && (flush || timeout_fire)) begin
            emit     = 1'b1;
            lanes_d  = '0;
            groups_d = '0;
            data_d   = '0;
            weight_d = '0;
            len_d    = '0;
        end
        state_d = (groups_d != '0) ? StFilling : StEmpty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StEmpty;
            lanes_q      <= '0;
            groups_q     <= '0;
            data_q       <= '0;
            weight_q     <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_groups_q <= '0;
            out_len_q    <= '0;
            out_data_q   <= '0;
            out_weight_q <= '0;
        end else begin
            state_q     <= state_d;
            lanes_q     <= lanes_d;
            groups_q    <= groups_d;
            data_q      <= data_d;
            weight_q    <= weight_d;
            len_q       <= len_d;
            err_q       <= err_d;
            out_valid_q <= emit;
            if (emit) begin
                out_groups_q <= emit_groups;
                out_len_q    <= emit_len;
                out_data_q   <= emit_data;
                out_weight_q <= emit_weight;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_num_groups = out_groups_q;
    assign out_num_macs   = out_len_q;
    assign out_data       = out_data_q;
    assign out_weight     = out_weight_q;
    assign err_len        = err_q;

endmodule
